// File: rtl/ring_arbiter.sv
// Token-ring station arbiter: passes upstream slots through, converts an
// arriving token into a grant for one of three local requesters (round-robin),
// forwards the owner's slots while it drives the ring, then re-issues the token.
module ring_arbiter #(
  parameter int MAX_HOLD = 64  // slots per grant including header; must be <= 127
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  whichCore,
  input  logic [31:0] RingIn,
  input  logic [3:0]  SlotTypeIn,
  input  logic [3:0]  SourceIn,
  output logic [31:0] RingOut,
  output logic [3:0]  SlotTypeOut,
  output logic [3:0]  SourceOut,
  input  logic [2:0]  wantsToken,
  output logic [2:0]  acquireToken,
  input  logic [2:0]  driveRing,
  input  logic [31:0] reqRingOut0,
  input  logic [31:0] reqRingOut1,
  input  logic [31:0] reqRingOut2,
  input  logic [3:0]  reqSlotTypeOut0,
  input  logic [3:0]  reqSlotTypeOut1,
  input  logic [3:0]  reqSlotTypeOut2,
  input  logic [3:0]  reqSourceOut0,
  input  logic [3:0]  reqSourceOut1,
  input  logic [3:0]  reqSourceOut2,
  output logic        collision,
  output logic        overrun
);

  localparam logic [3:0] SLOT_TOKEN = 4'd1;
  localparam logic [3:0] SLOT_NULL  = 4'd7;
  localparam logic [6:0] HOLD_LIMIT = 7'(MAX_HOLD);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_reg;
  logic [1:0]  owner_reg;
  logic [1:0]  rr_ptr_reg;
  logic [6:0]  hold_count_reg;

  logic [31:0] req_ring [3];
  logic [3:0]  req_type [3];
  logic [3:0]  req_src  [3];

  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic [1:0]  cand1;
  logic [1:0]  cand2;

  // Index arithmetic modulo the three requesters.
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign req_ring[0] = reqRingOut0;
  assign req_ring[1] = reqRingOut1;
  assign req_ring[2] = reqRingOut2;
  assign req_type[0] = reqSlotTypeOut0;
  assign req_type[1] = reqSlotTypeOut1;
  assign req_type[2] = reqSlotTypeOut2;
  assign req_src[0]  = reqSourceOut0;
  assign req_src[1]  = reqSourceOut1;
  assign req_src[2]  = reqSourceOut2;

  // Round-robin pick among live requesters, only when idle and a token arrives.
  always_comb begin
    cand1       = inc3(rr_ptr_reg);
    cand2       = inc3(cand1);
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    if (state_reg == IDLE && SlotTypeIn == SLOT_TOKEN) begin
      if (wantsToken[rr_ptr_reg]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_ptr_reg;
      end else if (wantsToken[cand1]) begin
        grant_valid = 1'b1;
        grant_idx   = cand1;
      end else if (wantsToken[cand2]) begin
        grant_valid = 1'b1;
        grant_idx   = cand2;
      end
    end
  end

  // One-hot grant strobe; suppressed while reset is held so nobody latches a
  // grant that the state machine is about to forget.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_acq
      assign acquireToken[gi] = grant_valid && !reset && (grant_idx == 2'(gi));
    end
  endgenerate

  // Arbiter state machine with registered slot output and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      owner_reg      <= 2'd0;
      rr_ptr_reg     <= 2'd0;
      hold_count_reg <= 7'd0;
      RingOut        <= 32'd0;
      SlotTypeOut    <= SLOT_NULL;
      SourceOut      <= 4'd0;
      collision      <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            // Token absorbed; the winner's header goes out in its place.
            RingOut        <= req_ring[grant_idx];
            SlotTypeOut    <= req_type[grant_idx];
            SourceOut      <= req_src[grant_idx];
            hold_count_reg <= 7'd1;
            owner_reg      <= grant_idx;
            state_reg      <= BUSY;
          end else begin
            RingOut     <= RingIn;
            SlotTypeOut <= SlotTypeIn;
            SourceOut   <= SourceIn;
          end
        end
        BUSY: begin
          // Upstream traffic is dropped while we own the ring; anything that
          // was not an empty slot is lost data.
          if (SlotTypeIn != SLOT_NULL) begin
            collision <= 1'b1;
          end
          if (driveRing[owner_reg] && hold_count_reg < HOLD_LIMIT) begin
            RingOut        <= req_ring[owner_reg];
            SlotTypeOut    <= req_type[owner_reg];
            SourceOut      <= req_src[owner_reg];
            hold_count_reg <= hold_count_reg + 7'd1;
          end else begin
            // Release: emit a fresh token stamped with our ring number.
            if (driveRing[owner_reg]) begin
              overrun <= 1'b1;
            end
            RingOut        <= 32'd0;
            SlotTypeOut    <= SLOT_TOKEN;
            SourceOut      <= whichCore;
            rr_ptr_reg     <= inc3(owner_reg);
            hold_count_reg <= 7'd0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_arbiter.sv
// Bench for ring_arbiter: a table of per-cycle vectors plus a hand-written
// reset-during-grant sequence; expected slots go through a scoreboard queue.
module tb_ring_arbiter;

  localparam logic [3:0] T_TOK = 4'd1;
  localparam logic [3:0] T_NUL = 4'd7;
  localparam logic [3:0] T_MSG = 4'd8;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  whichCore;
  logic [31:0] RingIn;
  logic [3:0]  SlotTypeIn;
  logic [3:0]  SourceIn;
  logic [31:0] RingOut;
  logic [3:0]  SlotTypeOut;
  logic [3:0]  SourceOut;
  logic [2:0]  wantsToken;
  logic [2:0]  acquireToken;
  logic [2:0]  driveRing;
  logic [31:0] reqRingOut0, reqRingOut1, reqRingOut2;
  logic [3:0]  reqSlotTypeOut0, reqSlotTypeOut1, reqSlotTypeOut2;
  logic [3:0]  reqSourceOut0, reqSourceOut1, reqSourceOut2;
  logic        collision;
  logic        overrun;

  ring_arbiter #(.MAX_HOLD(4)) dut (
    .clock(clock), .reset(reset), .whichCore(whichCore),
    .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
    .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
    .wantsToken(wantsToken), .acquireToken(acquireToken), .driveRing(driveRing),
    .reqRingOut0(reqRingOut0), .reqRingOut1(reqRingOut1), .reqRingOut2(reqRingOut2),
    .reqSlotTypeOut0(reqSlotTypeOut0), .reqSlotTypeOut1(reqSlotTypeOut1),
    .reqSlotTypeOut2(reqSlotTypeOut2),
    .reqSourceOut0(reqSourceOut0), .reqSourceOut1(reqSourceOut1),
    .reqSourceOut2(reqSourceOut2),
    .collision(collision), .overrun(overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [31:0] in_ring;
    logic [3:0]  in_type;
    logic [3:0]  in_src;
    logic [2:0]  want;
    logic [2:0]  drive;
    logic [31:0] word;      // requester i presents word+i
    logic [2:0]  exp_acq;
    logic [31:0] exp_ring;
    logic [3:0]  exp_type;
    logic [3:0]  exp_src;
    logic        exp_coll;
    logic        exp_ovr;
  } vec_t;

  typedef struct {
    logic [31:0] ring;
    logic [3:0]  typ;
    logic [3:0]  src;
    logic        coll;
    logic        ovr;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic rst, input logic [31:0] in_ring,
                              input logic [3:0] in_type, input logic [3:0] in_src,
                              input logic [2:0] want, input logic [2:0] drive,
                              input logic [31:0] word, input logic [2:0] exp_acq,
                              input logic [31:0] exp_ring, input logic [3:0] exp_type,
                              input logic [3:0] exp_src, input logic exp_coll,
                              input logic exp_ovr);
    vec_t v;
    v.rst = rst; v.in_ring = in_ring; v.in_type = in_type; v.in_src = in_src;
    v.want = want; v.drive = drive; v.word = word; v.exp_acq = exp_acq;
    v.exp_ring = exp_ring; v.exp_type = exp_type; v.exp_src = exp_src;
    v.exp_coll = exp_coll; v.exp_ovr = exp_ovr;
    return v;
  endfunction

  // Drive one cycle, check the combinational grant, then the registered slot.
  task automatic step(input vec_t v, input string name);
    exp_t e;
    exp_t p;
    reset       = v.rst;
    RingIn      = v.in_ring;
    SlotTypeIn  = v.in_type;
    SourceIn    = v.in_src;
    wantsToken  = v.want;
    driveRing   = v.drive;
    reqRingOut0 = v.word;
    reqRingOut1 = v.word + 32'd1;
    reqRingOut2 = v.word + 32'd2;
    p.ring = v.exp_ring; p.typ = v.exp_type; p.src = v.exp_src;
    p.coll = v.exp_coll; p.ovr = v.exp_ovr;
    sb_q.push_back(p);
    #1;
    checks++;
    if (acquireToken !== v.exp_acq) begin
      failures++;
      $display("FAIL %s acquireToken actual=%b required=%b", name, acquireToken, v.exp_acq);
    end
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    checks++;
    if ({RingOut, SlotTypeOut, SourceOut} !== {e.ring, e.typ, e.src}) begin
      failures++;
      $display("FAIL %s slot actual=%h/%0d/%0d required=%h/%0d/%0d", name,
               RingOut, SlotTypeOut, SourceOut, e.ring, e.typ, e.src);
    end
    checks++;
    if ({collision, overrun} !== {e.coll, e.ovr}) begin
      failures++;
      $display("FAIL %s flags actual=coll%b/ovr%b required=coll%b/ovr%b", name,
               collision, overrun, e.coll, e.ovr);
    end
    $display("%s: acq=%b out=%h/%0d/%0d coll=%b ovr=%b", name, acquireToken,
             RingOut, SlotTypeOut, SourceOut, collision, overrun);
  endtask

  initial begin
    whichCore       = 4'd3;
    reqSlotTypeOut0 = T_MSG; reqSlotTypeOut1 = T_MSG; reqSlotTypeOut2 = T_MSG;
    reqSourceOut0   = 4'd0;  reqSourceOut1   = 4'd1;  reqSourceOut2   = 4'd2;

    // Reset (grant must be suppressed even with a token and requests present)
    vecs.push_back(mk(1, 32'h0, T_TOK, 4'd9, 3'b111, 3'b000, 32'h0, 3'b000, 32'h0, T_NUL, 4'd0, 0, 0));
    vecs.push_back(mk(1, 32'h5, T_MSG, 4'd5, 3'b000, 3'b000, 32'h0, 3'b000, 32'h0, T_NUL, 4'd0, 0, 0));
    // Pass-through of message, null and unwanted token
    vecs.push_back(mk(0, 32'hDEAD0001, T_MSG, 4'd5, 3'b000, 3'b000, 32'h0, 3'b000, 32'hDEAD0001, T_MSG, 4'd5, 0, 0));
    vecs.push_back(mk(0, 32'h11, T_NUL, 4'd2, 3'b000, 3'b000, 32'h0, 3'b000, 32'h11, T_NUL, 4'd2, 0, 0));
    vecs.push_back(mk(0, 32'h1234, T_TOK, 4'd6, 3'b000, 3'b000, 32'h0, 3'b000, 32'h1234, T_TOK, 4'd6, 0, 0));
    // Requester 0: header + 2 payload, non-owner noise ignored, then token from core 3
    vecs.push_back(mk(0, 32'h0, T_TOK, 4'd9, 3'b001, 3'b000, 32'h100, 3'b001, 32'h100, T_MSG, 4'd0, 0, 0));
    vecs.push_back(mk(0, 32'h0, T_NUL, 4'd0, 3'b001, 3'b001, 32'h200, 3'b000, 32'h200, T_MSG, 4'd0, 0, 0));
    vecs.push_back(mk(0, 32'h0, T_NUL, 4'd0, 3'b111, 3'b111, 32'h300, 3'b000, 32'h300, T_MSG, 4'd0, 0, 0));
    vecs.push_back(mk(0, 32'h0, T_NUL, 4'd0, 3'b111, 3'b110, 32'h0, 3'b000, 32'h0, T_TOK, 4'd3, 0, 0));
    // All three requesting: order continues 1, 2, 0
    vecs.push_back(mk(0, 32'h0, T_TOK, 4'd3, 3'b111, 3'b000, 32'h400, 3'b010, 32'h401, T_MSG, 4'd1, 0, 0));
    vecs.push_back(mk(0, 32'h0, T_NUL, 4'd0, 3'b111, 3'b000, 32'h0, 3'b000, 32'h0, T_TOK, 4'd3, 0, 0));
    vecs.push_back(mk(0, 32'h0, T_TOK, 4'd3, 3'b111, 3'b000, 32'h500, 3'b100, 32'h502, T_MSG, 4'd2, 0, 0));
    vecs.push_back(mk(0, 32'h0, T_NUL, 4'd0, 3'b111, 3'b000, 32'h0, 3'b000, 32'h0, T_TOK, 4'd3, 0, 0));
    vecs.push_back(mk(0, 32'h0, T_TOK, 4'd3, 3'b111, 3'b000, 32'h600, 3'b001, 32'h600, T_MSG, 4'd0, 0, 0));
    vecs.push_back(mk(0, 32'h0, T_NUL, 4'd0, 3'b111, 3'b000, 32'h0, 3'b000, 32'h0, T_TOK, 4'd3, 0, 0));
    // Request dropped in token cycle: token passes through
    vecs.push_back(mk(0, 32'h0, T_TOK, 4'd3, 3'b000, 3'b000, 32'h0, 3'b000, 32'h0, T_TOK, 4'd3, 0, 0));
    // Pointer at 1, requests 0 and 2: wraps to 2; then 2 overruns MAX_HOLD=4
    vecs.push_back(mk(0, 32'h0, T_TOK, 4'd3, 3'b101, 3'b000, 32'h700, 3'b100, 32'h702, T_MSG, 4'd2, 0, 0));
    vecs.push_back(mk(0, 32'h0, T_NUL, 4'd0, 3'b100, 3'b100, 32'h800, 3'b000, 32'h802, T_MSG, 4'd2, 0, 0));
    vecs.push_back(mk(0, 32'h0, T_NUL, 4'd0, 3'b100, 3'b100, 32'h900, 3'b000, 32'h902, T_MSG, 4'd2, 0, 0));
    vecs.push_back(mk(0, 32'h0, T_NUL, 4'd0, 3'b100, 3'b100, 32'hA00, 3'b000, 32'hA02, T_MSG, 4'd2, 0, 0));
    vecs.push_back(mk(0, 32'h0, T_NUL, 4'd0, 3'b100, 3'b100, 32'hB00, 3'b000, 32'h0, T_TOK, 4'd3, 0, 1));
    vecs.push_back(mk(0, 32'h0, T_NUL, 4'd0, 3'b000, 3'b100, 32'h0, 3'b000, 32'h0, T_NUL, 4'd0, 0, 1));
    // Collision: message then token arrive while requester 1 owns the ring
    vecs.push_back(mk(0, 32'h0, T_TOK, 4'd3, 3'b010, 3'b000, 32'hC00, 3'b010, 32'hC01, T_MSG, 4'd1, 0, 1));
    vecs.push_back(mk(0, 32'h55, T_MSG, 4'd7, 3'b010, 3'b010, 32'hD00, 3'b000, 32'hD01, T_MSG, 4'd1, 1, 1));
    vecs.push_back(mk(0, 32'h0, T_TOK, 4'd9, 3'b010, 3'b010, 32'hE00, 3'b000, 32'hE01, T_MSG, 4'd1, 1, 1));
    vecs.push_back(mk(0, 32'h0, T_NUL, 4'd0, 3'b000, 3'b000, 32'h0, 3'b000, 32'h0, T_TOK, 4'd3, 1, 1));
    vecs.push_back(mk(0, 32'hCAFE, T_MSG, 4'd4, 3'b000, 3'b000, 32'h0, 3'b000, 32'hCAFE, T_MSG, 4'd4, 1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the second BUSY cycle: grant abandoned, Null out, no token,
    // pointer back at 0 so requester 0 wins over 1 afterwards.
    step(mk(0, 32'h0, T_TOK, 4'd3, 3'b001, 3'b000, 32'hF00, 3'b001, 32'hF00, T_MSG, 4'd0, 1, 1), "rst_grant");
    step(mk(0, 32'h0, T_NUL, 4'd0, 3'b001, 3'b001, 32'hF10, 3'b000, 32'hF10, T_MSG, 4'd0, 1, 1), "rst_busy1");
    step(mk(1, 32'h0, T_NUL, 4'd0, 3'b001, 3'b001, 32'hF20, 3'b000, 32'h0, T_NUL, 4'd0, 0, 0), "rst_busy2");
    step(mk(0, 32'h0, T_NUL, 4'd0, 3'b000, 3'b001, 32'hF30, 3'b000, 32'h0, T_NUL, 4'd0, 0, 0), "rst_after");
    step(mk(0, 32'h0, T_TOK, 4'd3, 3'b011, 3'b000, 32'h1000, 3'b001, 32'h1000, T_MSG, 4'd0, 0, 0), "rst_regrant0");
    step(mk(0, 32'h0, T_NUL, 4'd0, 3'b011, 3'b000, 32'h0, 3'b000, 32'h0, T_TOK, 4'd3, 0, 0), "rst_release0");
    step(mk(0, 32'h0, T_TOK, 4'd3, 3'b011, 3'b000, 32'h1100, 3'b010, 32'h1101, T_MSG, 4'd1, 0, 0), "rst_regrant1");
    step(mk(0, 32'h0, T_NUL, 4'd0, 3'b000, 3'b000, 32'h0, 3'b000, 32'h0, T_TOK, 4'd3, 0, 0), "rst_release1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_arbiter.md
RING_ARBITER -- requirements
Module: ring_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 64: maximum consecutive driven slots per grant, including header.
REQ-002 clock  input  1  the single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 whichCore  input  4  this core's ring number.
REQ-005 RingIn / SlotTypeIn / SourceIn  input  32/4/4  slot arriving from the upstream station.
REQ-006 RingOut / SlotTypeOut / SourceOut  output  32/4/4  registered slot sent downstream.
REQ-007 wantsToken  input  3  bit i: requester i wants the token (bit 0 is the messenger).
REQ-008 acquireToken  output  3  bit i: combinational one-hot grant to requester i.
REQ-009 driveRing  input  3  bit i: requester i is supplying the current slot.
REQ-010 reqRingOut0..2 / reqSlotTypeOut0..2 / reqSourceOut0..2  input  32/4/4 each  requester slot contents.
REQ-011 collision  output  1  sticky: a non-Null slot or a second token was overwritten.
REQ-012 overrun  output  1  sticky: a grant was force-released at MAX_HOLD.

Function
REQ-013 Slot types SHALL be Token=1, Null=7, Message=8.
REQ-014 State machine SHALL have two states: IDLE and BUSY; BUSY holds a 2-bit owner index.
REQ-015 IDLE, SlotTypeIn!=Token: the output registers SHALL load RingIn/SlotTypeIn/SourceIn unchanged, with 1-cycle latency.
REQ-016 IDLE, SlotTypeIn==Token, wantsToken==0: the token SHALL pass through unchanged.
REQ-017 IDLE, SlotTypeIn==Token, wantsToken!=0: select g, the first set bit searching rrPtr, rrPtr+1, rrPtr+2 (mod 3).
REQ-018 In that grant case, acquireToken[g] SHALL be 1 for exactly that cycle.
REQ-019 In that grant case, the token SHALL be absorbed, the output registers SHALL load requester g's slot regardless of driveRing[g], holdCount<=1, and the next state SHALL be BUSY with owner=g.
REQ-020 acquireToken SHALL be 0 in every cycle not covered by REQ-018.
REQ-021 BUSY, driveRing[owner]=1, holdCount<MAX_HOLD: the output SHALL load the owner's slot and holdCount SHALL increment.
REQ-022 BUSY, driveRing[owner]=0: the output SHALL load the token slot (RingOut=0, SlotTypeOut=Token, SourceOut=whichCore).
REQ-023 In that release case, rrPtr SHALL become (owner+1) mod 3 and the next state SHALL be IDLE.
REQ-024 BUSY, driveRing[owner]=1, holdCount==MAX_HOLD: the arbiter SHALL release as in REQ-022/023 and set overrun.
REQ-025 In BUSY, every incoming slot SHALL be discarded; collision SHALL be set if that slot's SlotTypeIn!=Null, including Token.
REQ-026 Grant and release SHALL never occur in the same cycle; a token is re-issued at least one cycle after the last driven slot.
REQ-027 wantsToken and driveRing bits from non-owners SHALL be ignored in BUSY.
REQ-028 A requester dropping wantsToken in the token cycle SHALL NOT be granted.
REQ-029 holdCount SHALL be 7 bits and SHALL NOT wrap; MAX_HOLD SHALL be at most 127.
REQ-030 collision and overrun SHALL clear only on reset.

Reset
REQ-031 On reset: state=IDLE, rrPtr=0, holdCount=0.
REQ-032 On reset: RingOut=0, SlotTypeOut=Null, SourceOut=0, acquireToken=0, collision=0, overrun=0.
REQ-033 Reset asserted in BUSY SHALL abandon the grant without emitting a token; the next cycle SHALL emit a Null slot.

Verification
REQ-034 Token with wantsToken=000 -> RingOut/SlotTypeOut/SourceOut equal to the inputs one cycle later; acquireToken stays 000.
REQ-035 whichCore=3, wantsToken=001, token in; requester 0 drives header plus 2 payload words -> acquireToken=001 for 1 cycle.
REQ-036 Same stimulus as REQ-035 -> 3 Message slots out, then a Token with SourceOut=3, then rrPtr=1.
REQ-037 wantsToken=111 held over three token arrivals, each grant driven 1 cycle -> grant order 0,1,2; rrPtr returns to 0.
REQ-038 MAX_HOLD=4, requester 2 holds driveRing high for 10 cycles -> 4 driven slots, then a Token, and overrun=1.
REQ-039 During BUSY, inject a Message slot and then a Token slot -> both are absorbed and collision=1.
REQ-040 Reset in the 2nd cycle of BUSY -> SlotTypeOut=Null next cycle, state IDLE, no token emitted.
